// File: rtl/fdct_row_if.sv
// Sample-in / coefficient-out port bundle of the forward DCT row stage.
// The master modport is the driving side and the slave modport is the DCT itself.
interface fdct_row_if #(
   parameter int WIDTH_X = 16,
   parameter int WIDTH_Y = 16
);
   logic                      in_valid;
   logic [1:0]                in_mode;
   logic signed [WIDTH_X-1:0] x_in;
   logic                      in_ready;
   logic signed [WIDTH_Y-1:0] y_out;
   logic                      out_valid;
   logic [1:0]                dct_out;

   modport master (
      output in_valid, in_mode, x_in,
      input  in_ready, y_out, out_valid, dct_out
   );

   modport slave (
      input  in_valid, in_mode, x_in,
      output in_ready, y_out, out_valid, dct_out
   );
endinterface

// File: rtl/fdct_row.sv
// Forward 4/8-point HEVC integer DCT, row stage: takes serial samples, accumulates
// all coefficients in parallel with shift-add constant multiplies, then streams them out serially.
module fdct_row #(
   parameter int WIDTH_X   = 16,
   parameter int WIDTH_ACC = 27,
   parameter int WIDTH_Y   = 16,
   parameter int SHIFT_8   = 2,
   parameter int SHIFT_4   = 1
) (
   input logic        clk,
   input logic        rst_n,
   fdct_row_if.slave  bus
);
   localparam logic [1:0] MODE4 = 2'b01;
   localparam logic [1:0] MODE8 = 2'b10;

   localparam logic signed [7:0] COEF [0:7][0:7] = '{
      '{8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64},
      '{8'sd89,  8'sd75,  8'sd50,  8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89},
      '{8'sd83,  8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36,  8'sd36,  8'sd83},
      '{8'sd75, -8'sd18, -8'sd89, -8'sd50,  8'sd50,  8'sd89,  8'sd18, -8'sd75},
      '{8'sd64, -8'sd64, -8'sd64,  8'sd64,  8'sd64, -8'sd64, -8'sd64,  8'sd64},
      '{8'sd50, -8'sd89,  8'sd18,  8'sd75, -8'sd75, -8'sd18,  8'sd89, -8'sd50},
      '{8'sd36, -8'sd83,  8'sd83, -8'sd36, -8'sd36,  8'sd83, -8'sd83,  8'sd36},
      '{8'sd18, -8'sd50,  8'sd75, -8'sd89,  8'sd89, -8'sd75,  8'sd50, -8'sd18}
   };

   localparam logic signed [WIDTH_ACC-1:0] RND_8 = WIDTH_ACC'(1) << (SHIFT_8 - 1);
   localparam logic signed [WIDTH_ACC-1:0] RND_4 = WIDTH_ACC'(1) << (SHIFT_4 - 1);
   localparam logic signed [WIDTH_ACC-1:0] Y_MAX = WIDTH_ACC'((1 << (WIDTH_Y - 1)) - 1);
   localparam logic signed [WIDTH_ACC-1:0] Y_MIN = ~Y_MAX;

   // Every HEVC coefficient magnitude is a sum of at most four powers of two
   function automatic logic signed [WIDTH_ACC-1:0] cmul(input logic signed [WIDTH_X-1:0] x,
                                                       input logic signed [7:0] c);
      logic signed [WIDTH_ACC-1:0] xe;
      logic signed [WIDTH_ACC-1:0] p;
      logic [7:0]                  mag;
      xe  = WIDTH_ACC'(x);
      mag = c[7] ? 8'(-c) : 8'(c);
      case (mag)
         8'd64:   p = xe <<< 6;
         8'd89:   p = (xe <<< 6) + (xe <<< 4) + (xe <<< 3) + xe;
         8'd83:   p = (xe <<< 6) + (xe <<< 4) + (xe <<< 1) + xe;
         8'd75:   p = (xe <<< 6) + (xe <<< 3) + (xe <<< 1) + xe;
         8'd50:   p = (xe <<< 5) + (xe <<< 4) + (xe <<< 1);
         8'd36:   p = (xe <<< 5) + (xe <<< 2);
         8'd18:   p = (xe <<< 4) + (xe <<< 1);
         default: p = '0;
      endcase
      return c[7] ? -p : p;
   endfunction

   logic [2:0]                  idx;
   logic [1:0]                  row_mode;
   logic [1:0]                  last_mode;
   logic                        s1_valid;
   logic                        s1_last;
   logic signed [WIDTH_X-1:0]   s1_x;
   logic [2:0]                  s1_n;
   logic [1:0]                  s1_mode;
   logic signed [WIDTH_ACC-1:0] acc  [8];
   logic signed [WIDTH_ACC-1:0] prod [8];
   logic                        acc_done;
   logic [1:0]                  acc_mode;
   logic signed [WIDTH_Y-1:0]   res  [8];
   logic signed [WIDTH_Y-1:0]   bank [8];
   logic [1:0]                  bank_mode;
   logic                        str_active;
   logic [2:0]                  str_idx;

   logic [1:0] cur_mode;
   logic       mode_ok;
   logic       row_last;
   logic       busy;
   logic       accept;
   logic [2:0] last_beat;

   assign cur_mode  = (idx == 3'd0) ? bus.in_mode : row_mode;
   assign mode_ok   = (cur_mode == MODE4) || (cur_mode == MODE8);
   assign row_last  = (cur_mode == MODE8) ? (idx == 3'd7) : (idx == 3'd3);
   assign last_beat = (bank_mode == MODE8) ? 3'd7 : 3'd3;

   // A 4-point row following an 8-point one would reload the bank mid-stream, so hold it off
   assign busy         = s1_valid || acc_done || str_active || bus.out_valid;
   assign bus.in_ready = !((idx == 3'd0) && (bus.in_mode == MODE4) && (last_mode == MODE8) && busy);
   assign accept       = bus.in_valid && bus.in_ready && mode_ok;

   for (genvar k = 0; k < 8; k++) begin : g_lane
      localparam int K4 = (k << 1) & 7;
      logic signed [7:0]           coef;
      logic signed [WIDTH_ACC-1:0] shifted;
      assign coef    = (s1_mode == MODE8) ? COEF[k][s1_n] : COEF[K4][s1_n];
      assign prod[k] = cmul(s1_x, coef);
      assign shifted = (acc_mode == MODE8) ? (acc[k] >>> SHIFT_8) : (acc[k] >>> SHIFT_4);
      assign res[k]  = (shifted > Y_MAX) ? WIDTH_Y'(Y_MAX) :
                       (shifted < Y_MIN) ? WIDTH_Y'(Y_MIN) : WIDTH_Y'(shifted);
   end

   // Bank load and stream share an edge; the stream reads the old bank before it is overwritten
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx           <= '0;
         row_mode      <= '0;
         last_mode     <= '0;
         s1_valid      <= 1'b0;
         s1_last       <= 1'b0;
         s1_x          <= '0;
         s1_n          <= '0;
         s1_mode       <= '0;
         acc_done      <= 1'b0;
         acc_mode      <= '0;
         bank_mode     <= '0;
         str_active    <= 1'b0;
         str_idx       <= '0;
         bus.y_out     <= '0;
         bus.out_valid <= 1'b0;
         bus.dct_out   <= '0;
         for (int k = 0; k < 8; k++) begin
            acc[k]  <= '0;
            bank[k] <= '0;
         end
      end else begin
         if (accept) begin
            idx <= row_last ? 3'd0 : idx + 3'd1;
            if (idx == 3'd0) begin
               row_mode  <= bus.in_mode;
               last_mode <= bus.in_mode;
            end
         end

         s1_valid <= accept;
         if (accept) begin
            s1_x    <= bus.x_in;
            s1_n    <= idx;
            s1_mode <= cur_mode;
            s1_last <= row_last;
         end

         if (s1_valid) begin
            for (int k = 0; k < 8; k++) begin
               if (s1_n == 3'd0)
                  acc[k] <= prod[k] + ((s1_mode == MODE8) ? RND_8 : RND_4);
               else
                  acc[k] <= acc[k] + prod[k];
            end
         end
         acc_done <= s1_valid && s1_last;
         if (s1_valid && s1_last)
            acc_mode <= s1_mode;

         if (str_active) begin
            bus.y_out     <= bank[str_idx];
            bus.out_valid <= 1'b1;
            bus.dct_out   <= bank_mode;
            str_idx       <= str_idx + 3'd1;
            if (str_idx == last_beat)
               str_active <= 1'b0;
         end else begin
            bus.y_out     <= '0;
            bus.out_valid <= 1'b0;
            bus.dct_out   <= '0;
         end

         if (acc_done) begin
            for (int k = 0; k < 8; k++)
               bank[k] <= res[k];
            bank_mode  <= acc_mode;
            str_active <= 1'b1;
            str_idx    <= '0;
         end
      end
   end
endmodule
